spi_reg_target: RTL
===================

SPI_REG_TARGET -- requirements
Module: spi_reg_target

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8, meaning register and SPI data-byte width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, meaning register address width (8 cfg + 8 status registers).
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rstb.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rstb  input  1  asynchronous active-low reset.
REQ-006 ena  input  1  clock enable; 0 freezes all state.
REQ-007 mode  input  2  {cpol, cpha}, already synchronized.
REQ-008 spi_cs_n, spi_clk, spi_mosi  input  1 each  synchronized SPI controller signals.
REQ-009 spi_miso  output  1  serial read data.
REQ-010 reg_addr  output  ADDR_WIDTH  register address.
REQ-011 reg_rsel  output  1  0 selects rw (cfg) bank, 1 selects ro (status) bank for reads.
REQ-012 reg_wdata  output  REG_WIDTH  write data.
REQ-013 reg_we  output  1  single-cycle write strobe, rw bank only.
REQ-014 reg_rdata  input  REG_WIDTH  combinational read data for {reg_rsel, reg_addr}.

Function
REQ-015 Frame = spi_cs_n low, 2 bytes MSB first: command byte then data byte.
REQ-016 Command byte: bit7 = 1 write / 0 read; bit6 = reg_rsel; bits[ADDR_WIDTH-1:0] = address; remaining bits ignored.
REQ-017 Edges SHALL be detected from registered spi_clk; sample edge = rising when cpol==cpha, falling otherwise; shift edge = the opposite edge.
REQ-018 mode SHALL be captured on the clk where spi_cs_n falling is detected and held for the frame.
REQ-019 FSM states IDLE, CMD, DATA, DONE; IDLE->CMD on cs_n falling; CMD->DATA after 8th sample edge; DATA->DONE after 16th sample edge; DONE->IDLE on cs_n high; any state->IDLE when cs_n high.
REQ-020 reg_addr and reg_rsel SHALL update on the clk after the 8th sample edge and hold until the next frame's command completes.
REQ-021 Read: reg_rdata SHALL be loaded into the tx shift register one clk after reg_addr updates; first data bit driven on spi_miso before the first data-byte sample edge.
REQ-022 CPHA=0: spi_miso shifts on trailing edges; CPHA=1: on leading edges; MSB first.
REQ-023 Write: reg_wdata updated and reg_we pulsed high exactly one clk, one clk after 16th sample edge; no reg_we for reads.
REQ-024 cs_n high before 16th sample edge SHALL abort: no reg_we, bit counter cleared, state IDLE.
REQ-025 Bits beyond 16 in DONE SHALL be ignored; spi_miso = 0 in DONE and IDLE.
REQ-026 Write to address with reg_rsel=1 SHALL be discarded (no reg_we).
REQ-027 Timing precondition: each spi_clk phase >= 4 clk cycles.

Reset
REQ-028 On rstb low: state IDLE, bit counter 0, spi_miso 0, reg_we 0, reg_addr 0, reg_rsel 0, reg_wdata 0, captured mode 0.
REQ-029 Reset mid-frame SHALL discard the frame; after release, block waits for next cs_n falling edge.

Structure
REQ-030 Shared package spi_pkg SHALL hold FSM state typedef, command bit positions (CMD_WR_BIT=7, CMD_SEL_BIT=6) and frame length constant 16.
REQ-031 One sub-module spi_edge_detect SHALL produce sample/shift/cs-fall strobes from spi_clk, spi_cs_n, captured mode.

Verification
REQ-032 Mode 0, write frame 0x83,0x5A -> one reg_we pulse, reg_addr=3, reg_wdata=0x5A.
REQ-033 Mode 3, read frame 0x42,0x00 with ro reg 2 = 0xAA -> reg_rsel=1, reg_addr=2, spi_miso bits 1,0,1,0,1,0,1,0.
REQ-034 Modes 1 and 2, read rw reg 5 = 0xC3 -> spi_miso returns 0xC3 in both modes.
REQ-035 Write 0x81,0xFF with cs_n raised after 12 bits -> no reg_we, next full frame 0x81,0x11 writes 0x11.
REQ-036 rstb low during data byte of write 0x80,0x77 -> no reg_we, all outputs at reset values, following frame works.
REQ-037 Write 0xC1,0x33 (ro bank) -> no reg_we; 24-bit frame 0x84,0x66,0x99 -> single write of 0x66 to address 4.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_pkg : shared types and constants for the SPI register target
// Revision: 1.0
// ----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_SEL_BIT = 6;
  localparam int CMD_LEN     = 8;
  localparam int FRAME_LEN   = 16;
  localparam int CNT_W       = $clog2(FRAME_LEN + 1);

endpackage
`default_nettype wire

// File: rtl/spi_reg_target_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_reg_target_if : SPI pins plus register-file access bus
// Revision: 1.0
// ----------------------------------------------------------------------------
interface spi_reg_target_if
  import spi_pkg::*;
#(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  spi_cs_n;
  logic                  spi_clk;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic                  reg_rsel;
  logic [REG_WIDTH-1:0]  reg_wdata;
  logic                  reg_we;
  logic [REG_WIDTH-1:0]  reg_rdata;

  modport slave (
    input  spi_cs_n, spi_clk, spi_mosi, reg_rdata,
    output spi_miso, reg_addr, reg_rsel, reg_wdata, reg_we
  );

  modport master (
    output spi_cs_n, spi_clk, spi_mosi, reg_rdata,
    input  spi_miso, reg_addr, reg_rsel, reg_wdata, reg_we
  );
endinterface
`default_nettype wire

// File: rtl/spi_edge_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_edge_detect : sample/shift/cs-fall strobes from synchronized SPI pins
// Revision: 1.0
// ----------------------------------------------------------------------------
module spi_edge_detect
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rstb,
  input  logic       ena,
  input  logic       spi_clk_i,
  input  logic       spi_cs_n_i,
  input  logic [1:0] mode_i,
  output logic       sample_o,
  output logic       shift_o,
  output logic       cs_fall_o
);
  logic sclk_q;
  logic csn_q;
  logic rise;
  logic fall;

  // cs_n history resets low so a select held low through reset is not
  // mistaken for a new frame.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sclk_q <= 1'b0;
      csn_q  <= 1'b0;
    end else if (ena) begin
      sclk_q <= spi_clk_i;
      csn_q  <= spi_cs_n_i;
    end
  end

  assign rise      = spi_clk_i & ~sclk_q;
  assign fall      = ~spi_clk_i & sclk_q;
  assign sample_o  = (mode_i[1] == mode_i[0]) ? rise : fall;
  assign shift_o   = (mode_i[1] == mode_i[0]) ? fall : rise;
  assign cs_fall_o = csn_q & ~spi_cs_n_i;

endmodule
`default_nettype wire

// File: rtl/spi_reg_target.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_reg_target : SPI target giving 2-byte command/data access to registers
// Revision: 1.0
// ----------------------------------------------------------------------------
module spi_reg_target
  import spi_pkg::*;
#(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 3
)(
  input  logic               clk,
  input  logic               rstb,
  input  logic               ena,
  input  logic [1:0]         mode,
  spi_reg_target_if.slave    bus
);
  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [1:0]            mode_q;
  logic [CMD_LEN-1:0]    cmd_q;
  logic [CMD_LEN-1:0]    cmd_d;
  logic [REG_WIDTH-1:0]  data_q;
  logic [REG_WIDTH-1:0]  data_d;
  logic [REG_WIDTH-1:0]  tx_q;
  logic                  miso_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rsel_q;
  logic [REG_WIDTH-1:0]  wdata_q;
  logic                  we_q;
  logic                  addr_pend_q;
  logic                  load_pend_q;
  logic                  wr_pend_q;
  logic                  sample;
  logic                  shift;
  logic                  cs_fall;
  logic                  shift_en;
  logic                  unused_cmd;

  spi_edge_detect u_edge (
    .clk        (clk),
    .rstb       (rstb),
    .ena        (ena),
    .spi_clk_i  (bus.spi_clk),
    .spi_cs_n_i (bus.spi_cs_n),
    .mode_i     (mode_q),
    .sample_o   (sample),
    .shift_o    (shift),
    .cs_fall_o  (cs_fall)
  );

  assign cmd_d      = {cmd_q[CMD_LEN-2:0], bus.spi_mosi};
  assign data_d     = {data_q[REG_WIDTH-2:0], bus.spi_mosi};
  assign unused_cmd = ^cmd_q;
  // CPHA=0 presents the MSB at load time, so the trailing edge of bit 8 must not shift.
  assign shift_en   = mode_q[0] ? (cnt_q >= CNT_W'(CMD_LEN)) : (cnt_q >= CNT_W'(CMD_LEN + 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mode_q      <= 2'b00;
      cmd_q       <= '0;
      data_q      <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      addr_q      <= '0;
      rsel_q      <= 1'b0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      addr_pend_q <= 1'b0;
      load_pend_q <= 1'b0;
      wr_pend_q   <= 1'b0;
    end else if (ena) begin
      we_q        <= 1'b0;
      addr_pend_q <= 1'b0;
      load_pend_q <= addr_pend_q;
      wr_pend_q   <= 1'b0;
      if (addr_pend_q) begin
        addr_q <= cmd_q[ADDR_WIDTH-1:0];
        rsel_q <= cmd_q[CMD_SEL_BIT];
      end
      if (wr_pend_q) begin
        we_q    <= 1'b1;
        wdata_q <= data_q;
      end
      if (bus.spi_cs_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        miso_q  <= 1'b0;
        tx_q    <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            miso_q <= 1'b0;
            if (cs_fall) begin
              mode_q  <= mode;
              cnt_q   <= '0;
              state_q <= ST_CMD;
            end
          end
          ST_CMD: begin
            if (sample) begin
              cmd_q <= cmd_d;
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(CMD_LEN - 1)) begin
                state_q     <= ST_DATA;
                addr_pend_q <= 1'b1;
              end
            end
          end
          ST_DATA: begin
            if (load_pend_q) begin
              if (cmd_q[CMD_WR_BIT]) begin
                tx_q <= '0;
              end else if (mode_q[0]) begin
                tx_q <= bus.reg_rdata;
              end else begin
                miso_q <= bus.reg_rdata[REG_WIDTH-1];
                tx_q   <= {bus.reg_rdata[REG_WIDTH-2:0], 1'b0};
              end
            end else if (shift && shift_en) begin
              miso_q <= tx_q[REG_WIDTH-1];
              tx_q   <= {tx_q[REG_WIDTH-2:0], 1'b0};
            end
            if (sample) begin
              data_q <= data_d;
              cnt_q  <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                state_q   <= ST_DONE;
                miso_q    <= 1'b0;
                wr_pend_q <= cmd_q[CMD_WR_BIT] & ~cmd_q[CMD_SEL_BIT];
              end
            end
          end
          ST_DONE: begin
            miso_q <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.spi_miso  = miso_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_rsel  = rsel_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;

endmodule
`default_nettype wire
